// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard controller for the 5-stage RV32 core. It handles the
//   hazards that bypassing cannot cover:
//     - load-use dependence in ID: one-cycle bubble into EX
//     - EX-stage redirect (taken branch, JAL, JALR): flush IF/ID and ID/EX
//     - data memory not ready: freeze the whole pipe, bubble into WB
//   It also keeps saturating stall/flush counters and a sticky timeout flag.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   IF_ID_RS1/RS2, IF_ID_UsesRS1/RS2  source operands of the ID instruction
//   IF_ID_MemWrite                    ID instruction is a store
//   ID_EX_MemRead, ID_EX_RDes         EX instruction is a load / its destination
//   EX_Redirect                       EX resolved a control-flow redirect
//   EX_MEM_MemAccess, dmem_ready      MEM access in flight / completes this cycle
//   PC_Write .. EX_MEM_Write          pipeline register enables
//   IF_ID_Flush .. MEM_WB_Flush       bubble insertion controls
//   stall_cycles, flush_count         saturating performance counters
//   mem_timeout                       sticky: a freeze lasted MAX_WAIT cycles
module hazard_stall_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic             IF_ID_UsesRS1,
    input  logic             IF_ID_UsesRS2,
    input  logic             IF_ID_MemWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RDes,
    input  logic             EX_Redirect,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    logic freeze_req_s;
    logic load_use_s;
    logic stall_inc_s;
    logic flush_inc_s;

    // Hazard detection. A store whose only dependence is its data operand
    // (RS2) is not stalled: store-data forwarding supplies the value in MEM.
    always_comb begin
        freeze_req_s = EX_MEM_MemAccess & ~dmem_ready;
        load_use_s   = ID_EX_MemRead && (ID_EX_RDes != 5'd0) &&
                       ((IF_ID_UsesRS1 && (ID_EX_RDes == IF_ID_RS1)) ||
                        (IF_ID_UsesRS2 && (ID_EX_RDes == IF_ID_RS2) && !IF_ID_MemWrite));
        // A redirect held off by a freeze is counted only when it takes effect.
        stall_inc_s  = freeze_req_s | (load_use_s & ~EX_Redirect);
        flush_inc_s  = EX_Redirect & ~freeze_req_s;
    end

    // Pipeline enables and flushes: freeze beats redirect beats load-use.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (!rst_n) begin
            PC_Write = 1'b1;
        end else if (freeze_req_s) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (EX_Redirect) begin
            // The load-use consumer, if any, is in ID and is being flushed.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            PC_Write    = 1'b1;
        end else if (load_use_s) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else begin
            PC_Write = 1'b1;
        end
    end

    // Next state, memory wait counter and sticky timeout flag.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (freeze_req_s) begin
                    state_d    = FREEZE;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    wait_cnt_d = WAIT_ZERO;
                end
            end
            FREEZE: begin
                if (freeze_req_s) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = WAIT_ZERO;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = WAIT_ZERO;
            end
        endcase
        // The freeze is never forced to complete; the flag only reports it.
        if (freeze_req_s && (wait_cnt_d == WAIT_MAX)) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_inc_s && (stall_cycles_q != CNT_ONES)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush_inc_s && (flush_count_q != CNT_ONES)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // State, wait counter, timeout flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= WAIT_ZERO;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: a table of single-cycle vectors
// followed by hand-written freeze/redirect, timeout and async-reset sequences.
// Expected control words go through a scoreboard queue; counters are tracked
// by a running model built from per-vector increment flags.
module tb_hazard_stall_unit;

    localparam int CNT_W = 32;

    // Control word order: {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    //                      IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}
    localparam logic [6:0] NORM = 7'b1111_000;
    localparam logic [6:0] FRZ  = 7'b0000_001;
    localparam logic [6:0] RED  = 7'b1111_110;
    localparam logic [6:0] LU   = 7'b0011_010;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mw;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       macc;
        logic       rdy;
        logic [6:0] ctrl;
        logic       si;
        logic       fi;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [4:0]       IF_ID_RS1, IF_ID_RS2, ID_EX_RDes;
    logic             IF_ID_UsesRS1, IF_ID_UsesRS2, IF_ID_MemWrite, ID_EX_MemRead;
    logic             EX_Redirect, EX_MEM_MemAccess, dmem_ready;
    logic             PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic             IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic             mem_timeout;

    int               n_checks;
    int               n_fail;
    vec_t             exp_q[$];
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    logic             exp_to;
    vec_t             tbl[15];
    vec_t             v;

    hazard_stall_unit #(.MAX_WAIT(16), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_ID_RS1        (IF_ID_RS1),
        .IF_ID_RS2        (IF_ID_RS2),
        .IF_ID_UsesRS1    (IF_ID_UsesRS1),
        .IF_ID_UsesRS2    (IF_ID_UsesRS2),
        .IF_ID_MemWrite   (IF_ID_MemWrite),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RDes       (ID_EX_RDes),
        .EX_Redirect      (EX_Redirect),
        .EX_MEM_MemAccess (EX_MEM_MemAccess),
        .dmem_ready       (dmem_ready),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .ID_EX_Write      (ID_EX_Write),
        .EX_MEM_Write     (EX_MEM_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
        .MEM_WB_Flush     (MEM_WB_Flush),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
        .mem_timeout      (mem_timeout)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic mw,
                                input logic mr, input logic [4:0] rd,
                                input logic redir, input logic macc, input logic rdy,
                                input logic [6:0] ctrl, input logic si, input logic fi);
        vec_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.mw = mw;
        r.mr = mr; r.rd = rd; r.redir = redir; r.macc = macc; r.rdy = rdy;
        r.ctrl = ctrl; r.si = si; r.fi = fi;
        return r;
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Drive one vector (called shortly after a rising edge), compare the
    // combinational controls mid-cycle, then compare the registered state
    // just after the next rising edge.
    task automatic drive_cycle(input vec_t dv, input string name);
        vec_t e;
        IF_ID_RS1        = dv.rs1;
        IF_ID_RS2        = dv.rs2;
        IF_ID_UsesRS1    = dv.u1;
        IF_ID_UsesRS2    = dv.u2;
        IF_ID_MemWrite   = dv.mw;
        ID_EX_MemRead    = dv.mr;
        ID_EX_RDes       = dv.rd;
        EX_Redirect      = dv.redir;
        EX_MEM_MemAccess = dv.macc;
        dmem_ready       = dv.rdy;
        exp_q.push_back(dv);
        #4;
        e = exp_q.pop_front();
        check({name, ".ctrl"}, 64'(ctrl_now()), 64'(e.ctrl));
        @(posedge clk);
        #1;
        if (e.si) exp_stall = exp_stall + 32'd1;
        if (e.fi) exp_flush = exp_flush + 32'd1;
        check({name, ".stall"}, 64'(stall_cycles), 64'(exp_stall));
        check({name, ".flush"}, 64'(flush_count), 64'(exp_flush));
        check({name, ".timeout"}, 64'(mem_timeout), 64'(exp_to));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        exp_to    = 1'b0;

        //            rs1    rs2   u1    u2    mw    mr    rd    red   macc  rdy   ctrl  si    fi
        tbl[0]  = mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // idle
        tbl[1]  = mk(5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, RED,  1'b0, 1'b1); // redirect + load-use
        tbl[2]  = mk(5'd5,  5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0); // add x6,x5,x1
        tbl[3]  = mk(5'd5,  5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // bubble in EX
        tbl[4]  = mk(5'd2,  5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // sw x5,0(x2)
        tbl[5]  = mk(5'd5,  5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0); // sw x7,0(x5)
        tbl[6]  = mk(5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // lw x0
        tbl[7]  = mk(5'd3,  5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU,   1'b1, 1'b0); // RS2 of R-type
        tbl[8]  = mk(5'd9,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // U/J-type
        tbl[9]  = mk(5'd8,  5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // I-type, no match
        tbl[10] = mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, 1'b0, 1'b0); // access ready at once
        tbl[11] = mk(5'd4,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, LU,   1'b1, 1'b0); // ready + load-use
        tbl[12] = mk(5'd4,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, FRZ,  1'b1, 1'b0); // freeze wins all
        tbl[13] = mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0); // back to RUN
        tbl[14] = mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, RED,  1'b0, 1'b1); // plain redirect

        // Reset state, including control defaults while rst_n is low.
        rst_n = 1'b0;
        v = mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, NORM, 1'b0, 1'b0);
        IF_ID_RS1 = v.rs1; IF_ID_RS2 = v.rs2; IF_ID_UsesRS1 = v.u1; IF_ID_UsesRS2 = v.u2;
        IF_ID_MemWrite = v.mw; ID_EX_MemRead = v.mr; ID_EX_RDes = v.rd;
        EX_Redirect = v.redir; EX_MEM_MemAccess = v.macc; dmem_ready = v.rdy;
        #2;
        check("reset.ctrl", 64'(ctrl_now()), 64'(NORM));
        check("reset.stall", 64'(stall_cycles), 64'd0);
        check("reset.flush", 64'(flush_count), 64'd0);
        check("reset.timeout", 64'(mem_timeout), 64'd0);
        EX_MEM_MemAccess = 1'b0;
        ID_EX_MemRead = 1'b0;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive_cycle(tbl[i], $sformatf("vec%0d", i));
        end

        // Memory freeze for three cycles with a redirect waiting in EX.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0,
                           FRZ, 1'b1, 1'b0), $sformatf("frzred%0d", i));
        end
        drive_cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1,
                       RED, 1'b0, 1'b1), "frzred.release");
        drive_cycle(tbl[0], "frzred.idle");

        // Back-to-back freezes with a one-cycle ready pulse in between.
        drive_cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
                       FRZ, 1'b1, 1'b0), "b2b.frz0");
        drive_cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1,
                       NORM, 1'b0, 1'b0), "b2b.ready");
        drive_cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
                       FRZ, 1'b1, 1'b0), "b2b.frz1");
        drive_cycle(tbl[0], "b2b.idle");

        // Timeout: flag appears after exactly 16 frozen cycles, freeze holds.
        v = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 1'b1, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            exp_to = (i >= 16) ? 1'b1 : 1'b0;
            drive_cycle(v, $sformatf("tmo%0d", i));
        end

        // Async reset mid-freeze: everything clears without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        exp_to    = 1'b0;
        check("midrst.ctrl", 64'(ctrl_now()), 64'(NORM));
        check("midrst.stall", 64'(stall_cycles), 64'(exp_stall));
        check("midrst.flush", 64'(flush_count), 64'(exp_flush));
        check("midrst.timeout", 64'(mem_timeout), 64'(exp_to));
        rst_n = 1'b1;

        // Freeze still requested: the wait count restarts from RUN.
        for (int i = 1; i <= 16; i++) begin
            exp_to = (i == 16) ? 1'b1 : 1'b0;
            drive_cycle(v, $sformatf("tmo2_%0d", i));
        end
        drive_cycle(tbl[0], "tmo2.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage RV32 core: covers the hazards that bypassing cannot, so the forwarding path never sees a producer too young to supply. Detects load-use dependences in ID and inserts a one-cycle bubble, flushes IF/ID and ID/EX on an EX-stage redirect (taken branch, JAL, JALR), and freezes the whole pipe while the data memory has not completed an access. It also keeps saturating stall and flush counters and a sticky memory-timeout flag. It sits beside the forwarding unit and drives the write-enable and flush inputs of the PC and every pipeline register.

## Interface
Parameters:
- MAX_WAIT, 16: data-memory wait cycles before timeout is flagged.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_RS1, IF_ID_RS2  in  5 each  source registers of the instruction in ID.
- IF_ID_UsesRS1, IF_ID_UsesRS2  in  1 each  ID instruction reads RS1/RS2; both are 0 for U-type and J-type, and IF_ID_UsesRS2 is 0 for I-type.
- IF_ID_MemWrite  in  1  ID instruction is a store.
- ID_EX_MemRead  in  1  EX instruction is a load.
- ID_EX_RDes  in  5  destination register of the EX instruction.
- EX_Redirect  in  1  EX resolved a taken branch, JAL or JALR.
- EX_MEM_MemAccess  in  1  MEM instruction performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  register enables.
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble (NOP, all control bits 0).
- stall_cycles  out  CNT_W  saturating count of load-use and freeze cycles.
- flush_count  out  CNT_W  saturating count of redirects.
- mem_timeout  out  1  sticky; set when a freeze reaches MAX_WAIT.

## Operation
- FSM states: RUN, FREEZE. Wait counter: wait_cnt, width clog2(MAX_WAIT+1).
- freeze_req = EX_MEM_MemAccess && !dmem_ready.
- load_use = ID_EX_MemRead && ID_EX_RDes != 0 && ((IF_ID_UsesRS1 && ID_EX_RDes == IF_ID_RS1) || (IF_ID_UsesRS2 && ID_EX_RDes == IF_ID_RS2 && !IF_ID_MemWrite)).
  - The store-data case (dependence through RS2 of a store only) raises no stall; store-data forwarding covers it.
- Control outputs are combinational from the state and inputs. Defaults: every enable is 1 and every flush is 0. Priority is freeze, then redirect, then load-use.
  - Freeze (freeze_req, in either state): PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write are 0; MEM_WB_Flush is 1. Other flushes are 0.
  - Redirect (EX_Redirect && !freeze_req): IF_ID_Flush = 1, ID_EX_Flush = 1, PC_Write = 1. A coincident load_use is ignored because its consumer is being flushed.
  - Load-use (load_use && !EX_Redirect && !freeze_req): PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1.
- Transitions:
  - RUN to FREEZE on freeze_req; wait_cnt is cleared to 1.
  - FREEZE to RUN on !freeze_req.
  - While freeze_req persists in FREEZE, wait_cnt increments and saturates at MAX_WAIT.
  - When wait_cnt reaches MAX_WAIT, mem_timeout is set. The freeze continues: no forced completion.
- Counters:
  - stall_cycles += 1 on each cycle with freeze_req or with an effective load-use stall.
  - flush_count += 1 on each effective redirect cycle.
  - Both saturate at all-ones.
- A redirect arriving during a freeze is deferred. ID_EX is frozen, so EX_Redirect stays high and is acted on in the first unfrozen cycle; it is counted once.

## Timing
- Reset (rst_n low, asynchronous): state = RUN, wait_cnt = 0, stall_cycles = 0, flush_count = 0, mem_timeout = 0.
  - While rst_n is low, all enables are 1 and all flushes are 0.
- Reset asserted mid-freeze returns to RUN immediately and clears mem_timeout.
- Control outputs have zero-cycle latency from their inputs. Counters, state and mem_timeout update on the rising edge after the qualifying cycle.
- A load-use stall lasts exactly one cycle. On the next cycle the bubble occupies EX, so load_use deasserts naturally.
- Back-to-back freezes (dmem_ready pulse between two accesses) produce a RUN cycle in between, and wait_cnt restarts at 1.
- dmem_ready high on the same cycle EX_MEM_MemAccess rises means no freeze and no state change.

## Test plan
- Load-use stall: lw x5 in EX (ID_EX_MemRead=1, ID_EX_RDes=5), add x6,x5,x1 in ID (UsesRS1=1, RS1=5).
  - Required: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly one cycle; stall_cycles goes 0→1.
- Store-data exemption: lw x5 in EX, sw x5,0(x2) in ID (RS2=5, UsesRS2=1, MemWrite=1).
  - Required: no stall.
  - With sw x7,0(x5) (RS1=5): one-cycle stall.
- x0 destination: lw x0 in EX with consumer RS1=0.
  - Required: no stall.
- Redirect with coincident load-use: EX_Redirect=1 and load_use=1 in the same cycle.
  - Required: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1; flush_count=1, stall_cycles unchanged.
- Memory freeze then redirect: EX_MEM_MemAccess=1, dmem_ready low for 3 cycles, EX_Redirect=1 throughout.
  - Required: all enables 0 and MEM_WB_Flush=1 for 3 cycles; then one redirect cycle; stall_cycles=3, flush_count=1.
- Timeout and async reset: dmem_ready held low with MAX_WAIT=16.
  - Required: mem_timeout=1 after 16 frozen cycles and the freeze is held.
  - Drop rst_n mid-freeze: state=RUN and all counters and flags 0 without waiting for a clock edge.
